// File: rtl/approx_mul_pkg.sv
// ---------------------------------------------------------------------------
// approx_mul_pkg
// Shared definitions for the row-serial approximate multiplier scheduler.
//   ROWS     : number of half-adder-array rows produced by the core
//   ROW_B_W  : width of one row's carry vector
//   ROW_T_W  : width of one row's sum vector
//   PROD_W   : width of the folded product
//   OP_W     : operand width fed to the core
//   state_t  : scheduler states (IDLE, ACC, DONE)
//   row_term : weight one core row into its 16-bit product contribution
// ---------------------------------------------------------------------------
package approx_mul_pkg;

    localparam int ROWS    = 4;
    localparam int ROW_B_W = 7;
    localparam int ROW_T_W = 9;
    localparam int PROD_W  = 16;
    localparam int OP_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // A row contributes (t + 4*b) shifted by two bit positions per row index.
    // Everything is kept at product width so wrap-around is plain mod 2^16.
    function automatic logic [PROD_W-1:0] row_term(
        input logic [1:0]         k,
        input logic [ROW_B_W-1:0] b,
        input logic [ROW_T_W-1:0] t
    );
        logic [PROD_W-1:0] sum;
        sum = {{(PROD_W-ROW_T_W){1'b0}}, t} + {{(PROD_W-ROW_B_W-2){1'b0}}, b, 2'b00};
        return sum << {k, 1'b0};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at the requester just
// after i_ptr and wraps, so the most recently served requester has the lowest
// priority next time.
//   i_req   : per-requester request vector
//   i_ptr   : index of the requester served last
//   i_en    : when low, no grant is produced
//   o_grant : one-hot grant (all zero when nothing wins)
//   o_idx   : encoded index of the winner (zero when nothing wins)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0] w_cand;
    logic          w_found;

    // Walk the candidates ptr+1, ptr+2, ... ptr+N (mod N) and take the first
    // one that is requesting. The extra bit on w_cand holds ptr+off before
    // the wrap is folded back into range.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int off = 1; off <= N; off++) begin
            w_cand = {1'b0, i_ptr} + SW'(off);
            if (w_cand >= SW'(N)) begin
                w_cand = w_cand - SW'(N);
            end
            if (!w_found && i_en && i_req[w_cand[IDX_W-1:0]]) begin
                w_found                     = 1'b1;
                o_grant[w_cand[IDX_W-1:0]] = 1'b1;
                o_idx                       = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/approx_mul_row_sched.sv
// ---------------------------------------------------------------------------
// approx_mul_row_sched
// Shares one external combinational approximate 8x8 multiplier core among
// NUM_REQ requesters. A round-robin winner's operands are registered onto the
// core, the core's four rows are folded into a 16-bit product one row per
// cycle, and the product is returned with the requester index.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid / req_ready : per-requester request and one-cycle grant pulse
//   req_x / req_y         : packed 8-bit operands, requester i at [8i+7:8i]
//   mul_x / mul_y         : registered operands driving the core
//   ha_b / ha_t           : core row k carry [7k+6:7k] and sum [9k+8:9k]
//   res_valid / res_ready : result handshake
//   res_product / res_id  : folded product and served requester index
// ---------------------------------------------------------------------------
module approx_mul_row_sched
    import approx_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [OP_W*NUM_REQ-1:0] req_x,
    input  logic [OP_W*NUM_REQ-1:0] req_y,
    output logic [OP_W-1:0]         mul_x,
    output logic [OP_W-1:0]         mul_y,
    input  logic [ROWS*ROW_B_W-1:0] ha_b,
    input  logic [ROWS*ROW_T_W-1:0] ha_t,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [PROD_W-1:0]       res_product,
    output logic [ID_W-1:0]         res_id
);

    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

    state_t               r_state;
    logic [OP_W-1:0]      r_mulX;
    logic [OP_W-1:0]      r_mulY;
    logic [PROD_W-1:0]    r_acc;
    logic [1:0]           r_row;
    logic                 r_resValid;
    logic [PROD_W-1:0]    r_resProduct;
    logic [ID_W-1:0]      r_resId;
    logic [ID_W-1:0]      r_rrPtr;

    logic                 w_arbEn;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grantIdx;
    logic [ROW_B_W-1:0]   w_rowB;
    logic [ROW_T_W-1:0]   w_rowT;
    logic [PROD_W-1:0]    w_accNext;

    // Grants are only offered while idle, so the arbiter is simply gated by
    // the state; its grant vector doubles as the req_ready pulse.
    assign w_arbEn = (r_state == IDLE);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rrPtr),
        .i_en    (w_arbEn),
        .o_grant (w_grant),
        .o_idx   (w_grantIdx)
    );

    // The operands stay registered until the next grant, so the core's rows
    // are stable for the whole fold; only the row index moves the select.
    assign w_rowB    = ha_b[r_row*ROW_B_W +: ROW_B_W];
    assign w_rowT    = ha_t[r_row*ROW_T_W +: ROW_T_W];
    assign w_accNext = r_acc + row_term(r_row, w_rowB, w_rowT);

    assign req_ready   = w_grant;
    assign mul_x       = r_mulX;
    assign mul_y       = r_mulY;
    assign res_valid   = r_resValid;
    assign res_product = r_resProduct;
    assign res_id      = r_resId;

    // Scheduler: IDLE picks a winner and loads the core, ACC folds one row
    // per cycle and publishes on the last row, DONE holds the result until
    // the consumer takes it. Reset drops any job in flight without a trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mulX       <= '0;
            r_mulY       <= '0;
            r_acc        <= '0;
            r_row        <= '0;
            r_resValid   <= 1'b0;
            r_resProduct <= '0;
            r_resId      <= '0;
            r_rrPtr      <= ID_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_mulX  <= req_x[w_grantIdx*OP_W +: OP_W];
                        r_mulY  <= req_y[w_grantIdx*OP_W +: OP_W];
                        r_resId <= w_grantIdx;
                        r_rrPtr <= w_grantIdx;
                        r_acc   <= '0;
                        r_row   <= '0;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_acc <= w_accNext;
                    r_row <= r_row + 2'd1;
                    if (r_row == LAST_ROW) begin
                        r_resProduct <= w_accNext;
                        r_resValid   <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (r_resValid && res_ready) begin
                        r_resValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
